dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's memory-stage interface.
- Accepts one load or store request per transaction from stage M: address, store data, funct3 and write enable.
- Applies a configurable wait-state latency and stalls the pipeline via stallM while the access is in flight.
- Stores: encodes sb/sh/sw into byte lanes and a byte-enable mask. Loads: returns the raw aligned word; byte/half extraction stays in the existing load decoder.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the internal array; must be a power of two.
- LATENCY, 1, wait states between accept and access; legal range 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ReqValidM  in  1  request present in stage M
- MemWriteM  in  1  1 = store, 0 = load
- Funct3M  in  3  RISC-V funct3 of the memory instruction
- AddrM  in  32  byte address (ALU result)
- WriteDataM  in  32  store data, right-aligned
- StallM  out  1  hold the pipeline (to the hazard unit)
- MemDataM  out  32  raw aligned read word
- RValidM  out  1  MemDataM valid this cycle
- ByteEnM  out  4  byte enables applied by the last store (observability)
- FaultM  out  1  last request was rejected (misaligned, illegal funct3 or out of range)

Behaviour:
- Clock and reset: one clock domain. reset is synchronous and active-low.
- Reset values: state IDLE, wait counter 0, StallM 0, MemDataM 0, RValidM 0, ByteEnM 0, FaultM 0. Array contents are not reset.
- State machine: IDLE, WAIT, DONE.
  - IDLE, ReqValidM=1: capture the request. If LATENCY>0, go to WAIT with cnt=LATENCY-1; otherwise go directly to DONE.
  - WAIT: if cnt==0, perform the access and go to DONE; else decrement cnt.
  - DONE: drive RValidM=1 for exactly one cycle, then return to IDLE.
  - Requests are accepted only in IDLE. A still-asserted ReqValidM during DONE is ignored.
- StallM = (state==IDLE & ReqValidM) | (state==WAIT). It is 0 in DONE, so the pipeline advances on the DONE cycle.
- Latency: a request accepted at cycle t gets RValidM at t+LATENCY+1. StallM is high for LATENCY+1 cycles.
- Access is performed on the transition into DONE. For LATENCY=0 that is the IDLE accept edge.
- Word index = AddrM[log2(DEPTH_WORDS)+1:2]. Any set bit above that field counts as out of range.
- Store encoding:
  - sb (000): lanes = {4{WriteDataM[7:0]}}, be = 4'b0001 << AddrM[1:0].
  - sh (001): lanes = {2{WriteDataM[15:0]}}, be = AddrM[1] ? 1100 : 0011.
  - sw (010): lanes = WriteDataM, be = 1111.
  - Only enabled bytes are written; the other bytes keep their old value.
- Load funct3 000/001/010/100/101 are legal. MemDataM = the full word at the index; extraction is done downstream.
- Faults:
  - Halfword access with AddrM[0]=1.
  - Word access with AddrM[1:0]≠0.
  - Store funct3 outside 000..010; load funct3 011/110/111.
  - Out-of-range address.
- On a fault: no array write, ByteEnM=0, MemDataM=0, FaultM=1. Timing and handshake are unchanged (RValidM still pulses).
- FaultM, ByteEnM and MemDataM hold their values until the next access completes.
- Reset mid-WAIT: the pending store is dropped entirely (no partial write), the state returns to IDLE and StallM=0.
- A store and a following load to the same word: the load observes the stored data (the write completes before the next accept).

Decomposition:
- Shared package:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, WAIT, DONE.
  - LAT_W = 4.
- One combinational sub-module, store_encoder:
  - Inputs: Funct3, AddrLo[1:0], WriteData.
  - Outputs: ByteEn[3:0], Lanes[31:0], Misaligned.
  - Reused for the fault check of loads.
- The array and FSM stay in dmem_responder.

Test Plan:
- LATENCY=1, sw 0xDEADBEEF to 0x10, then lw 0x10 → StallM high 2 cycles each; RValidM at t+2; MemDataM=0xDEADBEEF; ByteEnM=1111.
- After the first test, sb 0x5A to 0x13, then lw 0x10 → ByteEnM=1000; MemDataM=0x5AADBEEF.
- sh 0x1234 to 0x12, then lw 0x10 → MemDataM=0x1234BEEF. sh to 0x11 → FaultM=1, ByteEnM=0, word unchanged.
- LATENCY=0, back-to-back lw 0x0 with ReqValidM held high → one StallM cycle, RValidM in the next cycle, second request accepted only after DONE.
- LATENCY=3, sw 0xFFFFFFFF to 0x20, reset asserted (0) in the second WAIT cycle → StallM=0 the next cycle; a later lw 0x20 returns the prior value.
- lw at 0x400 with DEPTH_WORDS=256 → FaultM=1, MemDataM=0, RValidM pulses once.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - RISC-V load/store funct3 encodings
//   - responder FSM state encoding
//   - wait-state counter width
//   - f3_legal(): funct3 legality for loads and stores
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Stores only exist as sb/sh/sw; loads additionally allow lbu/lhu.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_responder_store_encoder.sv
// Combinational store lane/byte-enable encoder.
//   Funct3    in  3  memory funct3
//   AddrLo    in  2  byte offset within the word
//   WriteData in  32 right-aligned store data
//   ByteEn    out 4  byte enables for the addressed lanes
//   Lanes     out 32 store data replicated onto every lane
//   Misaligned out 1 access not naturally aligned for its size
// The size decode also covers lbu/lhu so the same alignment check serves
// loads. Unknown funct3 values report no enables and no misalignment; their
// legality is judged by the caller.
module store_encoder
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  Funct3,
  input  logic [1:0]  AddrLo,
  input  logic [31:0] WriteData,
  output logic [3:0]  ByteEn,
  output logic [31:0] Lanes,
  output logic        Misaligned
);

  always_comb begin
    ByteEn     = 4'b0000;
    Lanes      = WriteData;
    Misaligned = 1'b0;
    case (Funct3)
      F3_B, F3_BU: begin
        Lanes  = {4{WriteData[7:0]}};
        ByteEn = 4'b0001 << AddrLo;
      end
      F3_H, F3_HU: begin
        Lanes      = {2{WriteData[15:0]}};
        ByteEn     = AddrLo[1] ? 4'b1100 : 4'b0011;
        Misaligned = AddrLo[0];
      end
      F3_W: begin
        Lanes      = WriteData;
        ByteEn     = 4'b1111;
        Misaligned = |AddrLo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage.
//   clk, reset      clock, synchronous active-low reset
//   ReqValidM       request present in stage M
//   MemWriteM       1 = store, 0 = load
//   Funct3M         funct3 of the memory instruction
//   AddrM           byte address
//   WriteDataM      right-aligned store data
//   StallM          hold the pipeline while the access is in flight
//   MemDataM        raw aligned read word (held until the next access)
//   RValidM         one-cycle completion pulse
//   ByteEnM         byte enables of the last store (held)
//   FaultM          last request rejected (held)
// A request accepted in IDLE spends LATENCY cycles in WAIT, performs the
// access on the edge into DONE, and pulses RValidM during DONE.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValidM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] MemDataM,
  output logic        RValidM,
  output logic [3:0]  ByteEnM,
  output logic        FaultM
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t             r_state;
  logic [LAT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_f3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wd;
  logic [31:0]        r_rdata;
  logic               r_rvalid;
  logic [3:0]         r_be;
  logic               r_fault;
  logic [3:0][7:0]    r_mem [DEPTH_WORDS];

  logic               w_idle;
  logic               w_accept;
  logic               w_access;
  logic               w_src_we;
  logic [2:0]         w_src_f3;
  logic [31:0]        w_src_addr;
  logic [31:0]        w_src_wd;
  logic [IDX_W-1:0]   w_idx;
  logic               w_oor;
  logic [3:0]         w_be;
  logic [31:0]        w_lanes;
  logic               w_mis;
  logic               w_fault;
  logic               w_wr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && ReqValidM;
  assign StallM   = w_accept || (r_state == ST_WAIT);

  // With zero wait states the access happens on the accept edge, so the
  // live inputs feed the datapath; otherwise the captured request does.
  assign w_access = (w_accept && (LATENCY == 0)) ||
                    ((r_state == ST_WAIT) && (r_cnt == '0));

  assign w_src_we   = w_idle ? MemWriteM  : r_we;
  assign w_src_f3   = w_idle ? Funct3M    : r_f3;
  assign w_src_addr = w_idle ? AddrM      : r_addr;
  assign w_src_wd   = w_idle ? WriteDataM : r_wd;

  assign w_idx = w_src_addr[IDX_W+1:2];
  assign w_oor = |(w_src_addr >> (IDX_W + 2));

  store_encoder u_enc (
    .Funct3     (w_src_f3),
    .AddrLo     (w_src_addr[1:0]),
    .WriteData  (w_src_wd),
    .ByteEn     (w_be),
    .Lanes      (w_lanes),
    .Misaligned (w_mis)
  );

  assign w_fault = w_oor || w_mis || !f3_legal(w_src_we, w_src_f3);
  assign w_wr    = w_access && w_src_we && !w_fault;

  // Array is not reset, but a reset on the access edge suppresses the
  // write so an interrupted store leaves no partial update.
  always_ff @(posedge clk) begin
    if (reset && w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b] <= w_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_f3     <= 3'b000;
      r_addr   <= '0;
      r_wd     <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_be     <= 4'b0000;
      r_fault  <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_access) begin
        r_rvalid <= 1'b1;
        if (w_fault) begin
          r_rdata <= '0;
          r_be    <= 4'b0000;
          r_fault <= 1'b1;
        end else begin
          r_fault <= 1'b0;
          // Stores report their enables; loads report the word. Each keeps
          // the other's last value.
          if (w_src_we) r_be    <= w_be;
          else          r_rdata <= r_mem[w_idx];
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (ReqValidM) begin
            r_we   <= MemWriteM;
            r_f3   <= Funct3M;
            r_addr <= AddrM;
            r_wd   <= WriteDataM;
            if (LATENCY == 0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LAT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MemDataM = r_rdata;
  assign RValidM  = r_rvalid;
  assign ByteEnM  = r_be;
  assign FaultM   = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (LATENCY 0, 1, 3) driven from one directed/random
// sequence and compared against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LATS [3] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        rst [3];
  logic        req [3];
  logic        we  [3];
  logic [2:0]  f3  [3];
  logic [31:0] addr[3];
  logic [31:0] wd  [3];
  logic        stall[3];
  logic [31:0] mdata[3];
  logic        rv   [3];
  logic [3:0]  be   [3];
  logic        flt  [3];

  int checks   = 0;
  int failures = 0;

  // reference state
  logic [7:0]  mb [3][DEPTH*4];
  logic [31:0] e_data [3];
  logic [3:0]  e_be   [3];
  logic        e_fault[3];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_d0 (
    .clk(clk), .reset(rst[0]), .ReqValidM(req[0]), .MemWriteM(we[0]),
    .Funct3M(f3[0]), .AddrM(addr[0]), .WriteDataM(wd[0]), .StallM(stall[0]),
    .MemDataM(mdata[0]), .RValidM(rv[0]), .ByteEnM(be[0]), .FaultM(flt[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_d1 (
    .clk(clk), .reset(rst[1]), .ReqValidM(req[1]), .MemWriteM(we[1]),
    .Funct3M(f3[1]), .AddrM(addr[1]), .WriteDataM(wd[1]), .StallM(stall[1]),
    .MemDataM(mdata[1]), .RValidM(rv[1]), .ByteEnM(be[1]), .FaultM(flt[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_d3 (
    .clk(clk), .reset(rst[2]), .ReqValidM(req[2]), .MemWriteM(we[2]),
    .Funct3M(f3[2]), .AddrM(addr[2]), .WriteDataM(wd[2]), .StallM(stall[2]),
    .MemDataM(mdata[2]), .RValidM(rv[2]), .ByteEnM(be[2]), .FaultM(flt[2]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  // Reference: accesses are byte runs of 1/2/4 bytes in a flat byte array.
  task automatic model(input int d, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] dat);
    int size;
    bit legal, bad;
    int aw;
    size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f <= 3'd2) : (f == 3'd0 || f == 3'd1 || f == 3'd2 ||
                               f == 3'd4 || f == 3'd5);
    bad   = !legal || (a % size != 0) || (a >= DEPTH * 4);
    if (bad) begin
      e_data[d] = 32'h0; e_be[d] = 4'h0; e_fault[d] = 1'b1;
    end else begin
      e_fault[d] = 1'b0;
      if (w) begin
        for (int i = 0; i < size; i++) mb[d][a + i] = dat[8*i +: 8];
        e_be[d] = 4'(((1 << size) - 1) << (a % 4));
      end else begin
        aw = int'(a) & ~3;
        e_data[d] = {mb[d][aw+3], mb[d][aw+2], mb[d][aw+1], mb[d][aw]};
      end
    end
  endtask

  task automatic check_outs(input string tag, input int d);
    chk({tag, "_data"},  d, mdata[d], e_data[d]);
    chk({tag, "_be"},    d, 32'(be[d]), 32'(e_be[d]));
    chk({tag, "_fault"}, d, 32'(flt[d]), 32'(e_fault[d]));
  endtask

  // Called at negedge+1 with the DUT idle; returns at negedge+1 one cycle
  // after the completion cycle.
  task automatic txn(input int d, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] dat, input bit hold);
    model(d, w, f, a, dat);
    req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wd[d] = dat;
    #1;
    for (int c = 0; c <= LATS[d]; c++) begin
      chk("stall_busy", d, 32'(stall[d]), 32'd1);
      chk("rvalid_busy", d, 32'(rv[d]), 32'd0);
      @(negedge clk); #1;
    end
    chk("stall_done", d, 32'(stall[d]), 32'd0);
    chk("rvalid_done", d, 32'(rv[d]), 32'd1);
    check_outs("done", d);
    if (!hold) req[d] = 1'b0;
    @(negedge clk); #1;
    chk("rvalid_once", d, 32'(rv[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] a, dat;
    logic [2:0]  f;
    logic        w;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'd0;
      addr[d] = 32'h0; wd[d] = 32'h0;
      e_data[d] = 32'h0; e_be[d] = 4'h0; e_fault[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_stall", d, 32'(stall[d]), 32'd0);
      chk("rst_rvalid", d, 32'(rv[d]), 32'd0);
      check_outs("rst", d);
      rst[d] = 1'b1;
    end
    @(negedge clk); #1;

    // preload words 0..15 of each array so every later load is defined
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0);

    // LATENCY=1 directed store/load sequence
    txn(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("sw_be", 1, 32'(be[1]), 32'hF);
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("sw_lw_data", 1, mdata[1], 32'hDEADBEEF);
    txn(1, 1'b1, 3'b000, 32'h13, 32'h0000005A, 1'b0);
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("sb_be", 1, 32'(be[1]), 32'h8);
    chk("sb_lw_data", 1, mdata[1], 32'h5AADBEEF);
    txn(1, 1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0);
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("sh_lw_data", 1, mdata[1], 32'h1234BEEF);
    txn(1, 1'b1, 3'b001, 32'h11, 32'h0000ABCD, 1'b0);
    chk("sh_mis_fault", 1, 32'(flt[1]), 32'd1);
    chk("sh_mis_be", 1, 32'(be[1]), 32'h0);
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("sh_mis_unchanged", 1, mdata[1], 32'h1234BEEF);
    txn(1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0);
    chk("oor_fault", 1, 32'(flt[1]), 32'd1);
    chk("oor_data", 1, mdata[1], 32'h0);

    // LATENCY=0 back-to-back loads with ReqValidM held through DONE
    txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    chk("b2b_reaccept_stall", 0, 32'(stall[0]), 32'd1);
    txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

    // LATENCY=3 reset in the second WAIT cycle drops the store
    txn(2, 1'b1, 3'b010, 32'h20, 32'h13572468, 1'b0);
    req[2] = 1'b1; we[2] = 1'b1; f3[2] = 3'b010; addr[2] = 32'h20;
    wd[2] = 32'hFFFFFFFF;
    @(negedge clk);              // first WAIT cycle
    @(negedge clk);              // second WAIT cycle
    rst[2] = 1'b0; req[2] = 1'b0;
    @(negedge clk); #1;
    chk("midrst_stall", 2, 32'(stall[2]), 32'd0);
    chk("midrst_rvalid", 2, 32'(rv[2]), 32'd0);
    e_data[2] = 32'h0; e_be[2] = 4'h0; e_fault[2] = 1'b0;
    check_outs("midrst", 2);
    rst[2] = 1'b1;
    @(negedge clk); #1;
    txn(2, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    chk("midrst_prior", 2, mdata[2], 32'h13572468);

    // randomized traffic, mostly in the preloaded region
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        w   = 1'($urandom_range(0, 1));
        f   = 3'($urandom_range(0, 7));
        dat = $urandom;
        a   = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
        txn(d, w, f, a, dat, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
